// File: rtl/instr_adder_meas_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// instr_meas_pkg
// Shared types and constants for the adder ring-oscillator measurement
// controller: the controller state enum, phase lengths, synchronizer depth,
// edge-counter width, and a helper that builds active-low one-hot selects.
// No ports (package).
// ---------------------------------------------------------------------------
package instr_meas_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RUN,
      DRAIN,
      DONE
   } meas_state_e;

   localparam int SETUP_CYCLES = 4;
   localparam int DRAIN_CYCLES = 3;
   localparam int SYNC_STAGES  = 2;
   localparam int COUNT_W      = 16;

   // Every bit high except the selected index, which is pulled low.
   function automatic logic [31:0] oneHotLow(input logic [4:0] idx);
      oneHotLow = ~(32'd1 << idx);
   endfunction

endpackage

// File: rtl/instr_adder_meas_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_adder_meas_ctrl_if
// Command/response bundle between a host and the measurement controller.
//   Command : cmd_valid, cmd_ready, cmd_a, cmd_b, cmd_ring_bit, cmd_ext_en,
//             cmd_ext_bit, cmd_out_bit, cmd_window
//   Response: rsp_valid, rsp_ready, rsp_count, busy
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface instr_adder_meas_ctrl_if
   import instr_meas_pkg::*;
   ;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [31:0]        cmd_a;
   logic [31:0]        cmd_b;
   logic [4:0]         cmd_ring_bit;
   logic               cmd_ext_en;
   logic [4:0]         cmd_ext_bit;
   logic [4:0]         cmd_out_bit;
   logic [15:0]        cmd_window;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [COUNT_W-1:0] rsp_count;
   logic               busy;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_ring_bit, cmd_ext_en,
             cmd_ext_bit, cmd_out_bit, cmd_window, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_count, busy
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_ring_bit, cmd_ext_en,
             cmd_ext_bit, cmd_out_bit, cmd_window, rsp_ready,
      output cmd_ready, rsp_valid, rsp_count, busy
   );

endinterface

// File: rtl/instr_adder_meas_ctrl_ring_edge_sync.sv
// ---------------------------------------------------------------------------
// ring_edge_sync
// Brings the asynchronous ring-oscillator tap into the wb_clk_i domain
// through a SYNC_STAGES-deep flop chain and emits a one-cycle pulse for
// every rising edge seen on the synchronized signal.
//   wb_clk_i     in  clock
//   reset_n      in  synchronous active-low reset
//   ring_clk     in  asynchronous ring tap
//   edge_pulse_o out one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module ring_edge_sync
   import instr_meas_pkg::*;
(
   input  logic wb_clk_i,
   input  logic reset_n,
   input  logic ring_clk,
   output logic edge_pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw tap through the synchronizer and keep one extra flop of
   // history so a rising edge can be detected purely from registered values.
   always_ff @(posedge wb_clk_i) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ring_clk};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/instr_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// instr_adder_meas_ctrl
// Runs one ring-oscillator measurement on an instrumented adder: latches a
// command, drives operands and active-low bit selects to the adder, enables
// the ring for a window of W clocks, counts synchronized ring edges, and
// returns the count over a valid/ready response.
//   wb_clk_i           in  clock
//   reset_n            in  synchronous active-low reset
//   cmd_if             slave command/response bundle
//   a_input, b_input   out adder operands (0 when idle)
//   a_input_ring_bit_b out active-low ring bit select
//   a_input_ext_bit_b  out active-low external bit select (all ones if off)
//   s_output_bit_b     out active-low sum output select
//   ring_en            out ring enable, high only during the window
//   ring_clk           in  asynchronous ring tap
// ---------------------------------------------------------------------------
module instr_adder_meas_ctrl
   import instr_meas_pkg::*;
(
   input  logic                    wb_clk_i,
   input  logic                    reset_n,
   instr_adder_meas_ctrl_if.slave  cmd_if,
   output logic [31:0]             a_input,
   output logic [31:0]             b_input,
   output logic [31:0]             a_input_ring_bit_b,
   output logic [31:0]             a_input_ext_bit_b,
   output logic [31:0]             s_output_bit_b,
   output logic                    ring_en,
   input  logic                    ring_clk
);

   meas_state_e        state_q, state_d;
   logic [15:0]        phaseCnt_q, phaseCnt_d;
   logic [15:0]        lastRun_q, lastRun_d;
   logic [COUNT_W-1:0] edgeCnt_q, edgeCnt_d;
   logic [31:0]        opA_q, opA_d;
   logic [31:0]        opB_q, opB_d;
   logic [4:0]         ringBit_q, ringBit_d;
   logic               extEn_q, extEn_d;
   logic [4:0]         extBit_q, extBit_d;
   logic [4:0]         outBit_q, outBit_d;
   logic               edgePulse;
   logic               active;

   ring_edge_sync uSync (
      .wb_clk_i     (wb_clk_i),
      .reset_n      (reset_n),
      .ring_clk     (ring_clk),
      .edge_pulse_o (edgePulse)
   );

   // State register: everything returns to idle/zero on reset, which also
   // throws away any measurement in progress without a response.
   always_ff @(posedge wb_clk_i) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         phaseCnt_q <= '0;
         lastRun_q  <= '0;
         edgeCnt_q  <= '0;
         opA_q      <= '0;
         opB_q      <= '0;
         ringBit_q  <= '0;
         extEn_q    <= 1'b0;
         extBit_q   <= '0;
         outBit_q   <= '0;
      end else begin
         state_q    <= state_d;
         phaseCnt_q <= phaseCnt_d;
         lastRun_q  <= lastRun_d;
         edgeCnt_q  <= edgeCnt_d;
         opA_q      <= opA_d;
         opB_q      <= opB_d;
         ringBit_q  <= ringBit_d;
         extEn_q    <= extEn_d;
         extBit_q   <= extBit_d;
         outBit_q   <= outBit_d;
      end
   end

   // Next-state logic. phaseCnt_q times each phase; the run window is stored
   // as its last cycle index so a zero window still runs for one cycle.
   // Edges only count during RUN and DRAIN, where DRAIN lets edges already in
   // the synchronizer at the end of the window land in the count.
   always_comb begin
      state_d    = state_q;
      phaseCnt_d = phaseCnt_q;
      lastRun_d  = lastRun_q;
      edgeCnt_d  = edgeCnt_q;
      opA_d      = opA_q;
      opB_d      = opB_q;
      ringBit_d  = ringBit_q;
      extEn_d    = extEn_q;
      extBit_d   = extBit_q;
      outBit_d   = outBit_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_if.cmd_valid) begin
               opA_d      = cmd_if.cmd_a;
               opB_d      = cmd_if.cmd_b;
               ringBit_d  = cmd_if.cmd_ring_bit;
               extEn_d    = cmd_if.cmd_ext_en;
               extBit_d   = cmd_if.cmd_ext_bit;
               outBit_d   = cmd_if.cmd_out_bit;
               lastRun_d  = (cmd_if.cmd_window == 16'd0) ? 16'd0
                                                         : cmd_if.cmd_window - 16'd1;
               phaseCnt_d = '0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            edgeCnt_d = '0;
            if (phaseCnt_q == 16'(SETUP_CYCLES - 1)) begin
               phaseCnt_d = '0;
               state_d    = RUN;
            end else begin
               phaseCnt_d = phaseCnt_q + 16'd1;
            end
         end
         RUN: begin
            if (edgePulse && (edgeCnt_q != '1)) begin
               edgeCnt_d = edgeCnt_q + 1'b1;
            end
            if (phaseCnt_q == lastRun_q) begin
               phaseCnt_d = '0;
               state_d    = DRAIN;
            end else begin
               phaseCnt_d = phaseCnt_q + 16'd1;
            end
         end
         DRAIN: begin
            if (edgePulse && (edgeCnt_q != '1)) begin
               edgeCnt_d = edgeCnt_q + 1'b1;
            end
            if (phaseCnt_q == 16'(DRAIN_CYCLES - 1)) begin
               phaseCnt_d = '0;
               state_d    = DONE;
            end else begin
               phaseCnt_d = phaseCnt_q + 16'd1;
            end
         end
         DONE: begin
            if (cmd_if.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Adder-side and response outputs decode from registered state only, so
   // nothing combinational reaches an output from ring_clk.
   assign active             = (state_q != IDLE);
   assign a_input            = active ? opA_q : 32'd0;
   assign b_input            = active ? opB_q : 32'd0;
   assign a_input_ring_bit_b = active ? oneHotLow(ringBit_q) : 32'hFFFF_FFFF;
   assign a_input_ext_bit_b  = (active && extEn_q) ? oneHotLow(extBit_q) : 32'hFFFF_FFFF;
   assign s_output_bit_b     = active ? oneHotLow(outBit_q) : 32'hFFFF_FFFF;
   assign ring_en            = (state_q == RUN);
   assign cmd_if.cmd_ready   = (state_q == IDLE);
   assign cmd_if.busy        = active;
   assign cmd_if.rsp_valid   = (state_q == DONE);
   assign cmd_if.rsp_count   = edgeCnt_q;

endmodule

// File: tb/tb_instr_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_adder_meas_ctrl
// Directed bench for the adder measurement controller: reset values, a
// basic measurement with ring pulses, response backpressure, an external
// select disabled run, a zero-length window and a reset mid-window.
// ---------------------------------------------------------------------------
module tb_instr_adder_meas_ctrl;
   import instr_meas_pkg::*;

   logic        wb_clk_i = 1'b0;
   logic        reset_n  = 1'b0;
   logic        ring_clk = 1'b0;
   logic [31:0] a_input;
   logic [31:0] b_input;
   logic [31:0] a_input_ring_bit_b;
   logic [31:0] a_input_ext_bit_b;
   logic [31:0] s_output_bit_b;
   logic        ring_en;

   int checks   = 0;
   int failures = 0;

   instr_adder_meas_ctrl_if busIf ();

   instr_adder_meas_ctrl dut (
      .wb_clk_i           (wb_clk_i),
      .reset_n            (reset_n),
      .cmd_if             (busIf),
      .a_input            (a_input),
      .b_input            (b_input),
      .a_input_ring_bit_b (a_input_ring_bit_b),
      .a_input_ext_bit_b  (a_input_ext_bit_b),
      .s_output_bit_b     (s_output_bit_b),
      .ring_en            (ring_en),
      .ring_clk           (ring_clk)
   );

   // Free-running 100 MHz clock.
   always #5 wb_clk_i = ~wb_clk_i;

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Present a command on the bus and raise cmd_valid.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] ringBit, input logic extEn,
                                input logic [4:0] extBit, input logic [4:0] outBit,
                                input logic [15:0] window);
      busIf.cmd_a        = a;
      busIf.cmd_b        = b;
      busIf.cmd_ring_bit = ringBit;
      busIf.cmd_ext_en   = extEn;
      busIf.cmd_ext_bit  = extBit;
      busIf.cmd_out_bit  = outBit;
      busIf.cmd_window   = window;
      busIf.cmd_valid    = 1'b1;
   endtask

   // Called just after the accepting edge. Counts cycles until rsp_valid
   // (bounded), counts ring_en cycles, optionally drives five 3-high/3-low
   // ring pulses starting two cycles into RUN, checks the external select
   // every cycle and the other adder-side values once in SETUP.
   task automatic runUntilDone(input string tag, input logic [31:0] expA,
                               input logic [31:0] expB, input logic [31:0] expRing,
                               input logic [31:0] expExt, input logic [31:0] expOut,
                               input bit pulses, output int n, output int enCycles);
      n        = 0;
      enCycles = 0;
      while (busIf.rsp_valid !== 1'b1 && n < 200) begin
         if (ring_en === 1'b1) enCycles++;
         checkOutput({tag, "_ext_vec"}, a_input_ext_bit_b, expExt);
         if (n == 3) begin
            checkOutput({tag, "_a_input"}, a_input, expA);
            checkOutput({tag, "_b_input"}, b_input, expB);
            checkOutput({tag, "_ring_vec"}, a_input_ring_bit_b, expRing);
            checkOutput({tag, "_out_vec"}, s_output_bit_b, expOut);
         end
         ring_clk = pulses && (n >= 6) && (n < 36) && (((n - 6) % 6) < 3);
         step();
         n++;
      end
      ring_clk = 1'b0;
      checkOutput({tag, "_ext_vec_done"}, a_input_ext_bit_b, expExt);
   endtask

   int  n;
   int  enCycles;
   bit  sawValid;

   // Directed sequence.
   initial begin
      busIf.cmd_valid    = 1'b0;
      busIf.rsp_ready    = 1'b0;
      busIf.cmd_a        = '0;
      busIf.cmd_b        = '0;
      busIf.cmd_ring_bit = '0;
      busIf.cmd_ext_en   = 1'b0;
      busIf.cmd_ext_bit  = '0;
      busIf.cmd_out_bit  = '0;
      busIf.cmd_window   = '0;

      $display("[TB] reset check");
      reset_n = 1'b0;
      repeat (3) step();
      checkOutput("rst_a_input", a_input, 32'd0);
      checkOutput("rst_b_input", b_input, 32'd0);
      checkOutput("rst_ring_vec", a_input_ring_bit_b, 32'hFFFF_FFFF);
      checkOutput("rst_ext_vec", a_input_ext_bit_b, 32'hFFFF_FFFF);
      checkOutput("rst_out_vec", s_output_bit_b, 32'hFFFF_FFFF);
      checkOutput("rst_ring_en", 32'(ring_en), 32'd0);
      checkOutput("rst_rsp_valid", 32'(busIf.rsp_valid), 32'd0);
      checkOutput("rst_rsp_count", 32'(busIf.rsp_count), 32'd0);
      reset_n = 1'b1;
      step();
      checkOutput("rel_cmd_ready", 32'(busIf.cmd_ready), 32'd1);
      checkOutput("rel_busy", 32'(busIf.busy), 32'd0);

      $display("[TB] basic run");
      applyStimulus(32'h3, 32'h1, 5'd31, 1'b1, 5'd0, 5'd8, 16'd40);
      step();
      busIf.cmd_valid = 1'b0;
      checkOutput("basic_busy", 32'(busIf.busy), 32'd1);
      checkOutput("basic_cmd_ready", 32'(busIf.cmd_ready), 32'd0);
      runUntilDone("basic", 32'h3, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFE,
                   32'hFFFF_FEFF, 1'b1, n, enCycles);
      checkOutput("basic_latency", 32'(n), 32'd47);
      checkOutput("basic_ring_en_cycles", 32'(enCycles), 32'd40);
      checkOutput("basic_rsp_count", 32'(busIf.rsp_count), 32'd5);

      $display("[TB] backpressure");
      applyStimulus(32'hA5, 32'h5A, 5'd3, 1'b0, 5'd7, 5'd1, 16'd5);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("bp_rsp_valid", 32'(busIf.rsp_valid), 32'd1);
         checkOutput("bp_rsp_count", 32'(busIf.rsp_count), 32'd5);
         checkOutput("bp_cmd_ready", 32'(busIf.cmd_ready), 32'd0);
      end
      busIf.rsp_ready = 1'b1;
      step();
      busIf.rsp_ready = 1'b0;
      checkOutput("bp_idle_rsp_valid", 32'(busIf.rsp_valid), 32'd0);
      checkOutput("bp_idle_cmd_ready", 32'(busIf.cmd_ready), 32'd1);
      checkOutput("bp_idle_rsp_count", 32'(busIf.rsp_count), 32'd5);
      checkOutput("bp_idle_a_input", a_input, 32'd0);
      step();
      busIf.cmd_valid = 1'b0;
      checkOutput("bp_accept_busy", 32'(busIf.busy), 32'd1);

      $display("[TB] ext disabled run");
      runUntilDone("extoff", 32'hA5, 32'h5A, 32'hFFFF_FFF7, 32'hFFFF_FFFF,
                   32'hFFFF_FFFD, 1'b0, n, enCycles);
      checkOutput("extoff_latency", 32'(n), 32'd12);
      checkOutput("extoff_ring_en_cycles", 32'(enCycles), 32'd5);
      checkOutput("extoff_rsp_count", 32'(busIf.rsp_count), 32'd0);
      busIf.rsp_ready = 1'b1;
      step();
      busIf.rsp_ready = 1'b0;
      checkOutput("extoff_idle_cmd_ready", 32'(busIf.cmd_ready), 32'd1);
      checkOutput("extoff_idle_ext_vec", a_input_ext_bit_b, 32'hFFFF_FFFF);

      $display("[TB] zero window");
      applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 1'b1, 5'd31, 5'd31, 16'd0);
      step();
      busIf.cmd_valid = 1'b0;
      runUntilDone("zero", 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_FFFE,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, n, enCycles);
      checkOutput("zero_latency", 32'(n), 32'd8);
      checkOutput("zero_ring_en_cycles", 32'(enCycles), 32'd1);
      checkOutput("zero_rsp_count", 32'(busIf.rsp_count), 32'd0);
      busIf.rsp_ready = 1'b1;
      step();
      busIf.rsp_ready = 1'b0;
      checkOutput("zero_idle_cmd_ready", 32'(busIf.cmd_ready), 32'd1);

      $display("[TB] reset mid run");
      applyStimulus(32'h3, 32'h1, 5'd31, 1'b1, 5'd0, 5'd8, 16'd40);
      step();
      busIf.cmd_valid = 1'b0;
      repeat (14) step();
      checkOutput("midrst_ring_en_before", 32'(ring_en), 32'd1);
      reset_n = 1'b0;
      step();
      checkOutput("midrst_ring_en", 32'(ring_en), 32'd0);
      checkOutput("midrst_a_input", a_input, 32'd0);
      checkOutput("midrst_ring_vec", a_input_ring_bit_b, 32'hFFFF_FFFF);
      checkOutput("midrst_ext_vec", a_input_ext_bit_b, 32'hFFFF_FFFF);
      checkOutput("midrst_out_vec", s_output_bit_b, 32'hFFFF_FFFF);
      checkOutput("midrst_rsp_valid", 32'(busIf.rsp_valid), 32'd0);
      reset_n = 1'b1;
      step();
      checkOutput("midrst_cmd_ready", 32'(busIf.cmd_ready), 32'd1);
      checkOutput("midrst_busy", 32'(busIf.busy), 32'd0);
      sawValid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (busIf.rsp_valid === 1'b1) sawValid = 1'b1;
      end
      checkOutput("midrst_no_response", 32'(sawValid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_adder_meas_ctrl.md
INSTR_ADDER_MEAS_CTRL -- requirements
Module: instr_adder_meas_ctrl

Interface
REQ-001 SHALL have port: wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous reset, active-low.
REQ-003 SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_a in 32, cmd_b in 32 (operands).
REQ-004 SHALL have command ports: cmd_ring_bit in 5, cmd_ext_en in 1, cmd_ext_bit in 5, cmd_out_bit in 5 (bit indices).
REQ-005 SHALL have command port: cmd_window in 16  measurement window length in clocks.
REQ-006 SHALL have adder-side ports: a_input out 32, b_input out 32, a_input_ring_bit_b out 32, a_input_ext_bit_b out 32, s_output_bit_b out 32, ring_en out 1.
REQ-007 SHALL have adder-side port: ring_clk  in  1  asynchronous ring-oscillator tap (adder chain_out).
REQ-008 SHALL have response ports: rsp_valid out 1, rsp_ready in 1, rsp_count out 16 (synchronized ring_clk rising edges), busy out 1.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, RUN, DRAIN, DONE; cmd_ready = (state==IDLE); busy = (state!=IDLE).
REQ-010 SHALL, on cmd_valid&cmd_ready, latch all cmd_* fields and enter SETUP; cmd_* ignored outside IDLE.
REQ-011 SHALL drive a_input/b_input from latched operands in SETUP, RUN, DRAIN, DONE; 0 in IDLE.
REQ-012 SHALL drive bit_b vectors active-low one-hot (all ones except index bit = 0) in SETUP..DONE; all ones in IDLE.
REQ-013 SHALL hold a_input_ext_bit_b all ones when latched cmd_ext_en=0.
REQ-014 SHALL stay in SETUP exactly 4 cycles (SETUP_CYCLES), clearing the edge counter.
REQ-015 SHALL stay in RUN exactly W cycles with ring_en=1, W = cmd_window, cmd_window=0 treated as W=1; ring_en=0 in all other states.
REQ-016 SHALL stay in DRAIN exactly 3 cycles (DRAIN_CYCLES) to flush the synchronizer.
REQ-017 SHALL pass ring_clk through a 2-flop synchronizer plus rising-edge detector; counter increments by 1 per detected edge only in RUN and DRAIN.
REQ-018 SHALL saturate the 16-bit counter at 16'hFFFF (no wrap).
REQ-019 SHALL enter DONE 7+W cycles after the accepting edge, asserting rsp_valid with rsp_count = final counter value.
REQ-020 SHALL hold rsp_valid and rsp_count stable until rsp_ready; on rsp_valid&rsp_ready return to IDLE next cycle.
REQ-021 SHALL make cmd_ready rise only the cycle after response handshake; a cmd_valid presented in DONE is not accepted.
REQ-022 SHALL hold rsp_count at last value in IDLE; rsp_valid=0 outside DONE.

Reset
REQ-023 SHALL, with reset_n=0 at a clock edge, set: state=IDLE, a_input=0, b_input=0, all bit_b vectors 32'hFFFF_FFFF, ring_en=0, rsp_valid=0, rsp_count=0, counters/synchronizer flops=0.
REQ-024 SHALL abort any in-flight measurement on reset (any state) with no response issued; cmd_ready=1 the first cycle after reset_n returns high.

Structure
REQ-025 SHALL place state enum, SETUP_CYCLES=4, DRAIN_CYCLES=3, SYNC_STAGES=2, COUNT_W=16 in package instr_meas_pkg.
REQ-026 SHALL implement synchronizer plus edge detector as sub-module ring_edge_sync (in ring_clk, out edge pulse).
REQ-027 SHALL be 120-400 lines RTL, no latches, no combinational path from ring_clk to any output.

Verification
REQ-028 Reset check: hold reset_n=0 3 cycles -> all outputs match REQ-023; release -> cmd_ready=1, busy=0.
REQ-029 Basic run: a=0x3, b=0x1, ring_bit=31, ext_en=1, ext_bit=0, out_bit=8, W=40; 5 ring_clk pulses (3 high/3 low) starting RUN+2 -> a_input_ring_bit_b=0x7FFF_FFFF, a_input_ext_bit_b=0xFFFF_FFFE, s_output_bit_b=0xFFFF_FEFF, ring_en high exactly 40 cycles, rsp_valid 47 cycles after accept, rsp_count=5.
REQ-030 Zero window: cmd_window=0, ring_clk=0 -> ring_en high 1 cycle, rsp_valid 8 cycles after accept, rsp_count=0.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in DONE, cmd_valid=1 throughout -> rsp_valid/rsp_count stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle, new command accepted the cycle after.
REQ-032 Reset mid-RUN: reset_n=0 at RUN cycle 10 -> next cycle ring_en=0, vectors all ones, rsp_valid never asserted.
REQ-033 Ext disabled: cmd_ext_en=0, cmd_ext_bit=7 -> a_input_ext_bit_b=0xFFFF_FFFF in all states.
